// File: rtl/counter_scheduler_if.sv
// Bundle between the tick-run scheduler, its two requesters and the shared counter.
// The scheduler takes the slave modport. The requesters and the counter datapath take the master modport.
interface counter_scheduler_if #(
  parameter int CNT_W = 4
);
  // Handshake: reqX is a level that stays high until doneX pulses. lenX is valid while reqX is high.
  // grantX and doneX are single-cycle pulses from the scheduler. wrapped is valid only with doneX.
  logic             req0;
  logic [CNT_W-1:0] len0;
  logic             req1;
  logic [CNT_W-1:0] len1;
  logic [CNT_W-1:0] count_value;
  logic             count_carry;
  logic             count_enable;
  logic             grant0;
  logic             grant1;
  logic             done0;
  logic             done1;
  logic             wrapped;
  logic             busy;
  logic             error;

  modport master (
    output req0, len0, req1, len1, count_value, count_carry,
    input  count_enable, grant0, grant1, done0, done1, wrapped, busy, error
  );

  modport slave (
    input  req0, len0, req1, len1, count_value, count_carry,
    output count_enable, grant0, grant1, done0, done1, wrapped, busy, error
  );
endinterface

// File: rtl/counter_scheduler.sv
// Shares one up-counter between two requesters. Each run is N enable ticks, granted round-robin.
// After the run the scheduler checks that the counter advanced by N (modulo 2^CNT_W).
module counter_scheduler #(
  parameter int CNT_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  counter_scheduler_if.slave    bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             carry_q, carry_d;

  logic en_d, g0_d, g1_d, d0_d, d1_d, wrap_d, busy_d, err_d;
  logic             win;
  logic [CNT_W-1:0] win_len;

  assign state_dbg = state_q;

  // The next-cycle value of every output is computed here, so each output is a plain flop.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    target_d    = target_q;
    carry_d     = carry_q;
    en_d        = 1'b0;
    g0_d        = 1'b0;
    g1_d        = 1'b0;
    d0_d        = 1'b0;
    d1_d        = 1'b0;
    wrap_d      = 1'b0;
    err_d       = bus.error;
    win         = 1'b0;
    win_len     = '0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // ptr_q names the requester that wins a tie
          win         = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
          win_len     = win ? bus.len1 : bus.len0;
          owner_d     = win;
          remaining_d = win_len;
          target_d    = bus.count_value + win_len;
          carry_d     = 1'b0;
          g0_d        = !win;
          g1_d        = win;
          if (win_len != '0) begin
            state_d = RUN;
            en_d    = 1'b1;
          end else begin
            state_d = CHECK;
            d0_d    = !win;
            d1_d    = win;
          end
        end
      end

      RUN: begin
        carry_d     = carry_q | bus.count_carry;
        remaining_d = remaining_q - 1'b1;
        if (remaining_q == CNT_W'(1)) begin
          // The carry from the last tick must still reach wrapped, so use carry_d here.
          state_d = CHECK;
          d0_d    = !owner_q;
          d1_d    = owner_q;
          wrap_d  = carry_d;
        end else begin
          en_d = 1'b1;
        end
      end

      CHECK: begin
        ptr_d   = !owner_q;
        state_d = IDLE;
        if (bus.count_value != target_q) err_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      owner_q          <= 1'b0;
      ptr_q            <= 1'b0;
      remaining_q      <= '0;
      target_q         <= '0;
      carry_q          <= 1'b0;
      bus.count_enable <= 1'b0;
      bus.grant0       <= 1'b0;
      bus.grant1       <= 1'b0;
      bus.done0        <= 1'b0;
      bus.done1        <= 1'b0;
      bus.wrapped      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.error        <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      ptr_q            <= ptr_d;
      remaining_q      <= remaining_d;
      target_q         <= target_d;
      carry_q          <= carry_d;
      bus.count_enable <= en_d;
      bus.grant0       <= g0_d;
      bus.grant1       <= g1_d;
      bus.done0        <= d0_d;
      bus.done1        <= d1_d;
      bus.wrapped      <= wrap_d;
      bus.busy         <= busy_d;
      bus.error        <= err_d;
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler. It holds a behavioural 4-bit counter model with a load port and a one-tick skip.
module tb_counter_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  counter_scheduler_if #(.CNT_W(4)) bus ();

  counter_scheduler #(.CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- shared counter model (no reset) ----------------
  logic [3:0] cnt = 4'd0;
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       skip_arm = 1'b0;

  always @(posedge clock) begin
    if (load_en) cnt <= load_val;
    else if (bus.count_enable && !skip_arm) cnt <= cnt + 4'd1;
  end

  assign bus.count_value = cnt;
  assign bus.count_carry = bus.count_enable && (cnt == 4'hF);

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_counter(input logic [3:0] v);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clock);
    load_en  = 1'b0;
  endtask

  // Starts at a negedge while the scheduler is idle. Returns at the negedge of the IDLE cycle after done.
  task automatic run_one(input string tag, input int ch, input logic [3:0] len, input int skip_at,
                         input logic [3:0] exp_end, input logic exp_wrap, input logic exp_err);
    int   waited;
    int   en_cycles;
    int   done_k;
    logic got;
    logic fin;
    waited = 0; got = 1'b0; en_cycles = 0; done_k = -1; fin = 1'b0;
    skip_arm = 1'b0;
    if (ch == 0) begin bus.req0 = 1'b1; bus.len0 = len; end
    else         begin bus.req1 = 1'b1; bus.len1 = len; end
    exp_q.push_back({28'd0, exp_end});
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      waited++;
      got = (ch == 0) ? bus.grant0 : bus.grant1;
    end
    chk({tag, "_grant_seen"}, 32'(got), 32'd1);
    chk({tag, "_grant_latency"}, 32'(waited), 32'd1);
    for (int k = 0; k < 40 && !fin; k++) begin
      if (k > 0) @(negedge clock);
      skip_arm = 1'b0;
      if (bus.count_enable) begin
        en_cycles++;
        if (en_cycles == skip_at) skip_arm = 1'b1;
      end
      fin = (ch == 0) ? bus.done0 : bus.done1;
      if (fin) done_k = k;
    end
    chk({tag, "_done_seen"}, 32'(fin), 32'd1);
    chk({tag, "_done_latency"}, 32'(done_k), 32'(len));
    chk({tag, "_enable_cycles"}, 32'(en_cycles), 32'(len));
    chk({tag, "_end_value"}, 32'(bus.count_value), exp_q.pop_front());
    chk({tag, "_wrapped"}, 32'(bus.wrapped), 32'(exp_wrap));
    if (ch == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    @(negedge clock);
    chk({tag, "_error_after"}, 32'(bus.error), 32'(exp_err));
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  // Trace bits: {grant0, grant1, done0, done1, count_enable, busy}
  logic [5:0] trace_exp [10];

  initial begin
    trace_exp[0] = 6'b100011; trace_exp[1] = 6'b000011; trace_exp[2] = 6'b001001;
    trace_exp[3] = 6'b000000; trace_exp[4] = 6'b010011; trace_exp[5] = 6'b000011;
    trace_exp[6] = 6'b000011; trace_exp[7] = 6'b000101; trace_exp[8] = 6'b000000;
    trace_exp[9] = 6'b100011;

    reset = 1'b1;
    bus.req0 = 1'b0; bus.len0 = 4'd0;
    bus.req1 = 1'b0; bus.len1 = 4'd0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_outputs", 32'({bus.grant0, bus.grant1, bus.done0, bus.done1,
                              bus.count_enable, bus.wrapped, bus.busy, bus.error}), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    // Both requesters held: 0 first, then 1, then 0 again.
    bus.req0 = 1'b1; bus.len0 = 4'd2;
    bus.req1 = 1'b1; bus.len1 = 4'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("rr_trace_%0d", i + 1),
          32'({bus.grant0, bus.grant1, bus.done0, bus.done1, bus.count_enable, bus.busy}),
          32'(trace_exp[i]));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) @(negedge clock);
    chk("rr_idle_busy", 32'(bus.busy), 32'd0);
    chk("rr_error", 32'(bus.error), 32'd0);

    // Plain run: 3 + 5 = 8, no carry.
    load_counter(4'd3);
    run_one("t1", 0, 4'd5, 0, 4'd8, 1'b0, 1'b0);

    // Wrapping run: 13 + 4 = 1, carry seen at 15.
    load_counter(4'd13);
    run_one("t2", 1, 4'd4, 0, 4'd1, 1'b1, 1'b0);

    // Zero length: grant and done together, no enable.
    run_one("t4", 0, 4'd0, 0, 4'd1, 1'b0, 1'b0);

    // One tick swallowed: 2 + 6 lands on 7, not 8. error is sticky afterwards.
    load_counter(4'd2);
    run_one("t5a", 0, 4'd6, 3, 4'd7, 1'b0, 1'b1);
    run_one("t5b", 1, 4'd2, 0, 4'd9, 1'b0, 1'b1);

    // Reset during the 3rd RUN cycle of a length-8 run.
    load_counter(4'd5);
    bus.req0 = 1'b1; bus.len0 = 4'd8;
    @(negedge clock);
    chk("t6_grant0", 32'(bus.grant0), 32'd1);
    @(negedge clock);
    @(negedge clock);
    chk("t6_enable_run3", 32'(bus.count_enable), 32'd1);
    reset = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clock);
    chk("t6_after_reset", 32'({bus.count_enable, bus.busy, bus.done0, bus.error}), 32'd0);
    chk("t6_state", 32'(state_dbg), 32'd0);
    chk("t6_counter_kept", 32'(bus.count_value), 32'd8);
    reset = 1'b0;
    @(negedge clock);
    chk("t6_no_done", 32'({bus.done0, bus.done1}), 32'd0);
    run_one("t6b", 1, 4'd3, 0, 4'd11, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Shares one 4-bit ripple-enable up-counter (count_enable in; value and output carry out) between two requesters.
- Each requester asks for a run of N count ticks. The scheduler arbitrates round-robin and drives count_enable for exactly N cycles.
- It then checks the counter advanced by N modulo 2^CNT_W, and reports done, wrap and error status.
- Sits between the counter datapath and the blocks that need timed tick runs.

Parameters:
CNT_W, 4, width of the shared counter value and of each length request; all arithmetic is modulo 2^CNT_W

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all scheduler state on the clock edge where it is sampled high
req0  input  1  requester 0 run request, level, held until done0
len0  input  CNT_W  requester 0 tick count, valid while req0 high
req1  input  1  requester 1 run request, level, held until done1
len1  input  CNT_W  requester 1 tick count, valid while req1 high
count_value  input  CNT_W  current value of the shared counter
count_carry  input  1  shared counter output carry (all ones AND enable)
count_enable  output  1  enable to the shared counter
grant0  output  1  one-cycle pulse: run for requester 0 started
grant1  output  1  one-cycle pulse: run for requester 1 started
done0  output  1  one-cycle pulse: run for requester 0 finished
done1  output  1  one-cycle pulse: run for requester 1 finished
wrapped  output  1  valid with doneX: counter carry seen during the run
busy  output  1  high in every state except IDLE
error  output  1  sticky: end value mismatch detected; cleared only by reset

Behaviour:
- All outputs are registered. Reset values: count_enable, grantX, doneX, wrapped, busy and error = 0.
- Reset state: state = IDLE; round-robin pointer gives priority to requester 0.
- The counter itself has no reset and is not touched by reset.
- States: IDLE, RUN, CHECK.
- IDLE, cycle T, some reqX high:
  - Winner: the only requester if one; otherwise the requester with priority.
  - Latch owner, remaining = lenX, start = count_value, target = (count_value + lenX) mod 2^CNT_W, carry_seen = 0.
  - Transition on the edge ending cycle T:
    - To RUN if lenX != 0.
    - To CHECK if lenX == 0 (zero length: no enable cycles).
- The first cycle after IDLE (T+1) carries grantX = 1 for the owner, for one cycle. If that state is CHECK (len 0), grantX and doneX assert in the same cycle T+1.
- RUN:
  - count_enable = 1 in every RUN cycle, exactly len cycles (T+1 .. T+len).
  - remaining decrements each RUN cycle; the RUN cycle with remaining == 1 is the last.
  - carry_seen |= count_carry in each RUN cycle.
  - Next state CHECK.
- CHECK (cycle T+len+1, or T+1 for len 0):
  - count_enable = 0, doneX = 1 for the owner, wrapped = carry_seen.
  - If count_value != target, set error (stays 1).
  - Pointer moves so the non-owner gets priority.
  - Next state IDLE.
- Back in IDLE, any req still high is arbitrated as a fresh request. The earliest next grant is CHECK cycle + 2, so there is at least one IDLE cycle between runs.
- Requests arriving or dropping during RUN/CHECK are ignored until IDLE.
- lenX changes after the latch in IDLE have no effect.
- Wrap-around: target computation and comparison are modulo 2^CNT_W; 15 + 1 -> 0 for CNT_W = 4.
- Reset sampled in any state: next cycle is IDLE with all outputs 0 and count_enable deasserted immediately. The aborted run produces no doneX, and error is cleared.
- Throughput: one run per len+2 cycles (len+1 for the run, plus 1 IDLE).

Test Plan:
1. Counter at 3, req0 = 1, len0 = 5 -> grant0 at T+1; count_enable high T+1..T+5; done0 at T+6 with count_value = 8, wrapped = 0, error = 0.
2. Counter at 13, req1 = 1, len1 = 4 -> 4 enable cycles; count_carry seen; done1 with count_value = 1, wrapped = 1.
3. req0 and req1 both high from reset, len0 = 2, len1 = 3 -> order grant0, done0, one IDLE, grant1, done1. Both held again -> requester 0 served next (alternation).
4. req0 with len0 = 0 -> grant0 and done0 in the same cycle T+1, count_enable never asserted, error = 0.
5. Bench model forces count_value to skip one increment during a len = 6 run -> error rises in CHECK and stays 1 through later correct runs until reset.
6. reset pulsed in the 3rd RUN cycle of a len = 8 run -> count_enable low next cycle, no done0, busy = 0. A fresh request afterwards snapshots the current counter value and completes correctly.
